// File: rtl/fencei_flush_responder.sv
// Answers the core's fence.i flush handshake: drains data OBI traffic and the write buffer, optionally invalidates the icache, then pulses ack.
// Latency req->ack is 2 cycles when drained (3 with icache); the core must hold req until ack, and req must go low before the next flush.
module fencei_flush_responder #(
    parameter int OUTST_W        = 2,
    parameter bit ICACHE_PRESENT = 1'b1,
    parameter int INV_TIMEOUT    = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic fencei_flush_req_i,
    output logic fencei_flush_ack_o,
    input  logic data_req_i,
    input  logic data_gnt_i,
    input  logic data_rvalid_i,
    input  logic wbuf_empty_i,
    output logic icache_inv_req_o,
    input  logic icache_inv_ack_i,
    output logic flush_busy_o,
    output logic inv_timeout_o,
    output logic outst_err_o
);

    localparam int                 TMO_W     = $clog2(INV_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(INV_TIMEOUT - 1);
    localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        INVAL   = 3'd2,
        ACK     = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [OUTST_W-1:0] outst_cnt;
    logic [OUTST_W-1:0] outst_nxt;
    logic               outst_ovf;
    logic               outst_udf;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_hit;
    logic               drained;
    logic               txn_inc;
    logic               txn_dec;

    assign txn_inc = data_req_i & data_gnt_i;
    assign txn_dec = data_rvalid_i;

    // Saturating counter; out-of-range moves are flagged rather than wrapped.
    always_comb begin
        outst_nxt = outst_cnt;
        outst_ovf = 1'b0;
        outst_udf = 1'b0;
        if (txn_inc && !txn_dec) begin
            if (outst_cnt == OUTST_MAX) outst_ovf = 1'b1;
            else                        outst_nxt = outst_cnt + OUTST_W'(1);
        end else if (txn_dec && !txn_inc) begin
            if (outst_cnt == '0) outst_udf = 1'b1;
            else                 outst_nxt = outst_cnt - OUTST_W'(1);
        end
    end

    assign drained = (outst_nxt == '0) && wbuf_empty_i;
    assign tmo_hit = (tmo_cnt == TMO_LAST) && !icache_inv_ack_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            outst_cnt     <= '0;
            tmo_cnt       <= '0;
            inv_timeout_o <= 1'b0;
            outst_err_o   <= 1'b0;
        end else begin
            state     <= state_nxt;
            outst_cnt <= outst_nxt;
            tmo_cnt   <= (state == INVAL) ? tmo_cnt + TMO_W'(1) : '0;
            if (outst_ovf || outst_udf)
                outst_err_o <= 1'b1;
            if (state == INVAL && tmo_hit)
                inv_timeout_o <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fencei_flush_req_i) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!fencei_flush_req_i) state_nxt = IDLE;
                else if (drained)        state_nxt = ICACHE_PRESENT ? INVAL : ACK;
            end
            INVAL: begin
                // A withdrawn request still lets the invalidate finish, but is not acked.
                if (icache_inv_ack_i || tmo_hit)
                    state_nxt = fencei_flush_req_i ? ACK : IDLE;
            end
            ACK: begin
                state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!fencei_flush_req_i) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        icache_inv_req_o   = (state == INVAL);
        fencei_flush_ack_o = (state == ACK);
        flush_busy_o       = (state != IDLE);
    end

endmodule

// File: doc/fencei_flush_responder.md
Name: fencei_flush_responder

Overview:
- System-side responder for the core's fence.i flush handshake (fencei_flush_req / fencei_flush_ack).
- On a request it waits for the data-side OBI transactions to drain and for the external write buffer to empty. It then optionally invalidates the instruction cache and acknowledges.
- Sits at core boundary between the core's fencei handshake pins, the data OBI monitor and the icache invalidate port.

Parameters:
- OUTST_W, 2, width of outstanding-transaction counter; max tracked = 2^OUTST_W-1.
- ICACHE_PRESENT, 1, 1: run invalidate phase; 0: skip INVAL state entirely.
- INV_TIMEOUT, 255, max cycles in INVAL waiting for icache_inv_ack_i before forced exit; must be >=1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- fencei_flush_req_i  in  1  flush request from core; held high until ack seen
- fencei_flush_ack_o  out  1  single-cycle acknowledge
- data_req_i  in  1  data OBI req (monitor)
- data_gnt_i  in  1  data OBI gnt (monitor)
- data_rvalid_i  in  1  data OBI rvalid (monitor)
- wbuf_empty_i  in  1  external write buffer empty
- icache_inv_req_o  out  1  icache invalidate request, level, held until ack/timeout
- icache_inv_ack_i  in  1  icache invalidate done, single-cycle
- flush_busy_o  out  1  high in any state except IDLE
- inv_timeout_o  out  1  sticky: an invalidate timed out; cleared only by rst
- outst_err_o  out  1  sticky: counter overflow or rvalid with counter 0; cleared only by rst

Behaviour:
- Reset (async assert, rst=1): state=IDLE, outst_cnt=0, tmo_cnt=0; all outputs 0.
- Outstanding counter runs in every state:
  - +1 on data_req_i&data_gnt_i; -1 on data_rvalid_i; both in the same cycle leave it unchanged.
  - Increment at max saturates and sets outst_err_o.
  - Decrement at 0 stays 0 and sets outst_err_o.
- FSM, all transitions registered:
  - IDLE: fencei_flush_req_i=1 -> DRAIN.
  - DRAIN: drained = (outst_cnt==0 after this cycle's update) & wbuf_empty_i.
    - req=0 -> IDLE, no ack (request withdrawn).
    - else drained -> INVAL if ICACHE_PRESENT, otherwise ACK.
    - Request seen with counter already 0 and buffer empty: DRAIN lasts exactly 1 cycle.
  - INVAL: icache_inv_req_o=1; tmo_cnt increments each cycle, cleared on entry.
    - icache_inv_ack_i=1 -> ACK.
    - tmo_cnt==INV_TIMEOUT-1 with no ack -> set inv_timeout_o, go to ACK.
    - Ack and timeout in the same cycle: ack wins, inv_timeout_o not set.
    - req drop in INVAL is ignored: invalidate always completes. If req=0 on exit, go to IDLE instead of ACK.
  - ACK: fencei_flush_ack_o=1 for exactly this cycle -> RELEASE.
  - RELEASE: wait for req=0 -> IDLE. A new request is accepted only after req has been seen low for at least 1 cycle, so no double-ack on a held req.
- Outputs are driven from state (Moore):
  - icache_inv_req_o = (state==INVAL).
  - fencei_flush_ack_o = (state==ACK).
  - flush_busy_o = (state!=IDLE).
- Minimum latency req->ack (drained, ICACHE_PRESENT=0): req seen in cycle 0, DRAIN in cycle 1, ack in cycle 2.
- Minimum latency with ICACHE_PRESENT=1 and icache_inv_ack_i in the first INVAL cycle: ack in cycle 3.
- Reset mid-operation: immediate return to IDLE; any in-progress invalidate is dropped (icache_inv_req_o falls asynchronously); no ack is issued.
- Counter width arithmetic: OUTST_W bits unsigned, no wrap (saturating as above); tmo_cnt is $clog2(INV_TIMEOUT+1) bits.

Test Plan:
- Idle, drained, ICACHE_PRESENT=1: req rises at cycle 0, icache ack 2 cycles after inv_req rises -> inv_req high cycles 2-3, ack pulse cycle 4 (exactly 1 cycle), busy cycles 1-5, IDLE after req drops in cycle 5.
- Drain wait: 2 granted transactions outstanding, req at cycle 0, rvalids at cycles 3 and 6, wbuf_empty_i=1 -> DRAIN holds through cycle 6, INVAL entered cycle 7, outst_err_o=0.
- Timeout: INV_TIMEOUT=4, icache never acks -> inv_req high exactly 4 cycles, inv_timeout_o=1 sticky, ack still pulses once; a second flush with a prompt icache ack keeps inv_timeout_o=1.
- Withdrawal: req drops in DRAIN -> IDLE, no ack. Req drops in INVAL -> inv_req held until icache ack, then IDLE, no ack.
- Counter edges, OUTST_W=2: 4 grants with no rvalid -> count saturates at 3, outst_err_o=1. Simultaneous grant+rvalid at count 0 -> count stays 0, no error.
- Async reset asserted mid-INVAL -> icache_inv_req_o, busy and counters go to 0 without a clock edge; after release, a held req starts a fresh flush normally.
